// File: rtl/gate_bist_pkg.sv
// Shared types and step functions for the gate-model BIST harness.
// Step functions work on a fixed 64-bit carrier; the caller passes the live width.
package gate_bist_pkg;

   localparam int unsigned MaxW = 64;

   typedef logic [1:0] bist_state_t;

   localparam bist_state_t StIdle = 2'd0;
   localparam bist_state_t StRun  = 2'd1;
   localparam bist_state_t StDone = 2'd2;

   function automatic logic [MaxW-1:0] width_mask(input int unsigned w);
      logic [MaxW-1:0] m;
      m = '0;
      for (int i = 0; i < int'(MaxW); i++) begin
         m[i] = (i < int'(w));
      end
      return m;
   endfunction

   // Galois step: shift left, fold the bit shifted out of position w-1 back in via poly.
   function automatic logic [MaxW-1:0] lfsr_step(input logic [MaxW-1:0] v,
                                                 input logic [MaxW-1:0] poly,
                                                 input int unsigned     w);
      logic [MaxW-1:0] r;
      logic            msb;
      msb = 1'b0;
      for (int i = 0; i < int'(MaxW); i++) begin
         if (i == int'(w) - 1) msb = v[i];
      end
      r = (v << 1) & width_mask(w);
      if (msb) r = r ^ poly;
      return r & width_mask(w);
   endfunction

   function automatic logic [MaxW-1:0] misr_step(input logic [MaxW-1:0] v,
                                                 input logic [MaxW-1:0] poly,
                                                 input logic [MaxW-1:0] d,
                                                 input int unsigned     w);
      return lfsr_step(v, poly, w) ^ (d & width_mask(w));
   endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register compacting gate-model responses.
module gate_bist_misr
   import gate_bist_pkg::*;
#(
   parameter int unsigned           SIG_W     = 16,
   parameter int unsigned           OUT_W     = 10,
   parameter logic [SIG_W-1:0]      MISR_POLY = SIG_W'('h100B)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [OUT_W-1:0] d,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q, sig_d;

   if (OUT_W < 1 || OUT_W > SIG_W) begin : g_bad_out_w
      $error("gate_bist_misr: OUT_W must be in 1..SIG_W");
   end
   if (SIG_W < 2 || SIG_W > MaxW) begin : g_bad_sig_w
      $error("gate_bist_misr: SIG_W out of range");
   end

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = SIG_W'(misr_step(MaxW'(sig_q), MaxW'(MISR_POLY), MaxW'(d), SIG_W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule

// File: rtl/gate_model_bist.sv
// BIST harness: LFSR stimulus into an external gate model, MISR over its response,
// and a run/done FSM that compares the final signature against EXP_SIG.
module gate_model_bist
   import gate_bist_pkg::*;
#(
   parameter int unsigned      IN_W      = 21,
   parameter int unsigned      OUT_W     = 10,
   parameter int unsigned      SIG_W     = 16,
   parameter int unsigned      PATTERNS  = 1024,
   parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(1),
   parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'('h140000),
   parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'('h100B),
   parameter logic [SIG_W-1:0] EXP_SIG   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int unsigned CntW = $clog2(PATTERNS + 1);

   if (IN_W < 2 || IN_W > MaxW) begin : g_bad_in_w
      $error("gate_model_bist: IN_W out of range");
   end
   if (PATTERNS < 1) begin : g_bad_patterns
      $error("gate_model_bist: PATTERNS must be at least 1");
   end
   if (LFSR_SEED == '0) begin : g_bad_seed
      $error("gate_model_bist: LFSR_SEED of zero locks the LFSR");
   end

   bist_state_t      state_q, state_d;
   logic [IN_W-1:0]  lfsr_q, lfsr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             misr_clr, misr_en;
   logic [SIG_W-1:0] sig;

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      cnt_d    = cnt_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      // Abort wins over everything, including a simultaneous start.
      if (abort) begin
         state_d  = StIdle;
         lfsr_d   = LFSR_SEED;
         cnt_d    = '0;
         misr_clr = 1'b1;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_d  = StRun;
                  lfsr_d   = LFSR_SEED;
                  cnt_d    = '0;
                  misr_clr = 1'b1;
               end
            end
            StRun: begin
               misr_en = 1'b1;
               lfsr_d  = IN_W'(lfsr_step(MaxW'(lfsr_q), MaxW'(LFSR_POLY), IN_W));
               cnt_d   = cnt_q + CntW'(1);
               if (cnt_q == CntW'(PATTERNS - 1)) state_d = StDone;
            end
            default: begin
               state_d  = StIdle;
               lfsr_d   = LFSR_SEED;
               cnt_d    = '0;
               misr_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         lfsr_q  <= LFSR_SEED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
      end
   end

   gate_bist_misr #(
      .SIG_W     (SIG_W),
      .OUT_W     (OUT_W),
      .MISR_POLY (MISR_POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (misr_clr),
      .en  (misr_en),
      .d   (dut_out),
      .sig (sig)
   );

   assign dut_in    = lfsr_q;
   assign busy      = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign pass      = done && (sig == EXP_SIG);
   assign signature = sig;

endmodule

// File: tb/tb_gate_model_bist.sv
// Bench for gate_model_bist: two small hand-checked instances plus a wide instance
// driven randomly and compared every cycle against a behavioural model.
module tb_gate_model_bist;

   localparam int RP = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Small instance A: EXP_SIG=3, gate model is bitwise inversion.
   logic       a_rst, a_start, a_abort, a_busy, a_done, a_pass;
   logic [3:0] a_in, a_sig;
   gate_model_bist #(
      .IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(4), .LFSR_SEED(4'h1),
      .LFSR_POLY(4'h9), .MISR_POLY(4'h9), .EXP_SIG(4'h3)
   ) u_a (
      .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort), .dut_in(a_in),
      .dut_out(~a_in), .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig)
   );

   // Small instance Z: EXP_SIG=0, gate model switchable to a constant-zero stub.
   logic       z_rst, z_start, z_abort, z_busy, z_done, z_pass, z_zero;
   logic [3:0] z_in, z_sig, z_out;
   assign z_out = z_zero ? 4'h0 : ~z_in;
   gate_model_bist #(
      .IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(4), .LFSR_SEED(4'h1),
      .LFSR_POLY(4'h9), .MISR_POLY(4'h9), .EXP_SIG(4'h0)
   ) u_z (
      .clk(clk), .rst(z_rst), .start(z_start), .abort(z_abort), .dut_in(z_in),
      .dut_out(z_out), .busy(z_busy), .done(z_done), .pass(z_pass), .signature(z_sig)
   );

   // Wide instance R with a nonlinear gate model.
   logic        r_rst, r_start, r_abort, r_busy, r_done, r_pass;
   logic [20:0] r_in;
   logic [9:0]  r_out;
   logic [15:0] r_sig;

   function automatic logic [9:0] gate_fn(input logic [20:0] x);
      return (x[9:0] & x[19:10]) ^ x[20:11];
   endfunction

   assign r_out = gate_fn(r_in);

   gate_model_bist #(
      .PATTERNS(RP)
   ) u_r (
      .clk(clk), .rst(r_rst), .start(r_start), .abort(r_abort), .dut_in(r_in),
      .dut_out(r_out), .busy(r_busy), .done(r_done), .pass(r_pass), .signature(r_sig)
   );

   // Reference arithmetic: multiply by x modulo the feedback polynomial.
   function automatic logic [20:0] ref_lfsr(input logic [20:0] x);
      int v;
      v = int'(x) * 2;
      if (v >= (1 << 21)) v = (v - (1 << 21)) ^ 'h140000;
      return 21'(v);
   endfunction

   function automatic logic [15:0] ref_misr(input logic [15:0] m, input logic [9:0] d);
      int v;
      v = int'(m) * 2;
      if (v >= (1 << 16)) v = (v - (1 << 16)) ^ 'h100B;
      return 16'(v ^ int'(d));
   endfunction

   function automatic logic [15:0] full_run_sig();
      logic [20:0] l;
      logic [15:0] s;
      l = 21'd1;
      s = 16'd0;
      for (int k = 0; k < RP; k++) begin
         s = ref_misr(s, gate_fn(l));
         l = ref_lfsr(l);
      end
      return s;
   endfunction

   // Model: phase 0 idle, 1 running, 2 finished; k counts patterns consumed.
   bit          m_valid = 1'b0;
   int          m_ph    = 0;
   int          m_k     = 0;
   logic [20:0] m_lfsr  = 21'd1;
   logic [15:0] m_sig   = 16'd0;

   always @(posedge clk) begin
      if (r_rst || r_abort || (m_ph != 1 && r_start)) begin
         if (r_rst) m_valid <= 1'b1;
         m_ph   <= (!r_rst && !r_abort) ? 1 : 0;
         m_lfsr <= 21'd1;
         m_sig  <= 16'd0;
         m_k    <= 0;
      end else if (m_ph == 1) begin
         m_sig  <= ref_misr(m_sig, gate_fn(m_lfsr));
         m_lfsr <= ref_lfsr(m_lfsr);
         m_k    <= m_k + 1;
         if (m_k + 1 == RP) m_ph <= 2;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("r_busy", 32'(r_busy), 32'(m_ph == 1));
         check("r_done", 32'(r_done), 32'(m_ph == 2));
         check("r_pass", 32'(r_pass), 32'(m_ph == 2 && m_sig == 16'h0));
         check("r_dut_in", 32'(r_in), 32'(m_lfsr));
         check("r_signature", 32'(r_sig), 32'(m_sig));
      end
   end

   logic [3:0]  exp_in [4];
   logic [15:0] exp_full;

   initial begin
      exp_in[0] = 4'h1; exp_in[1] = 4'h2; exp_in[2] = 4'h4; exp_in[3] = 4'h8;
      {a_start, a_abort, z_start, z_abort, r_start, r_abort, z_zero} = '0;
      {a_rst, z_rst, r_rst} = 3'b111;
      tick();
      tick();
      {a_rst, z_rst, r_rst} = 3'b000;

      check("rst_busy", 32'(r_busy), 32'd0);
      check("rst_done", 32'(r_done), 32'd0);
      check("rst_pass", 32'(r_pass), 32'd0);
      check("rst_dut_in", 32'(r_in), 32'd1);
      check("rst_sig", 32'(r_sig), 32'd0);
      check("rst_a_dut_in", 32'(a_in), 32'd1);

      // A: walking-one stimulus, start mid-run ignored, known signature 3.
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("a_busy_run", 32'(a_busy), 32'd1);
         check("a_done_run", 32'(a_done), 32'd0);
         check("a_dut_in_seq", 32'(a_in), 32'(exp_in[i]));
         a_start = (i == 1);
         tick();
      end
      a_start = 1'b0;
      check("a_done", 32'(a_done), 32'd1);
      check("a_busy_end", 32'(a_busy), 32'd0);
      check("a_sig", 32'(a_sig), 32'h3);
      check("a_pass", 32'(a_pass), 32'd1);
      tick();
      check("a_done_level", 32'(a_done), 32'd1);

      // Z: same stream but EXP_SIG=0 fails; rerun from DONE with zero stub passes.
      z_start = 1'b1;
      tick();
      z_start = 1'b0;
      repeat (4) tick();
      check("z_done", 32'(z_done), 32'd1);
      check("z_pass_bad", 32'(z_pass), 32'd0);
      check("z_sig", 32'(z_sig), 32'h3);
      z_zero  = 1'b1;
      z_start = 1'b1;
      tick();
      z_start = 1'b0;
      check("z_rerun_busy", 32'(z_busy), 32'd1);
      check("z_rerun_dut_in", 32'(z_in), 32'd1);
      repeat (4) tick();
      check("z_stub_sig", 32'(z_sig), 32'h0);
      check("z_stub_pass", 32'(z_pass), 32'd1);

      // R: reset three cycles into a run.
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
      repeat (3) tick();
      r_rst = 1'b1;
      tick();
      r_rst = 1'b0;
      check("midrst_busy", 32'(r_busy), 32'd0);
      check("midrst_dut_in", 32'(r_in), 32'd1);
      check("midrst_sig", 32'(r_sig), 32'd0);
      check("midrst_done", 32'(r_done), 32'd0);

      // R: abort together with start while running.
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
      repeat (2) tick();
      check("pre_abort_busy", 32'(r_busy), 32'd1);
      r_abort = 1'b1;
      r_start = 1'b1;
      tick();
      {r_abort, r_start} = 2'b00;
      check("abort_busy", 32'(r_busy), 32'd0);
      check("abort_done", 32'(r_done), 32'd0);
      check("abort_dut_in", 32'(r_in), 32'd1);
      tick();
      check("abort_no_restart", 32'(r_busy), 32'd0);

      // R: two back-to-back runs both give the replayed signature.
      exp_full = full_run_sig();
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
      repeat (RP) tick();
      check("run1_done", 32'(r_done), 32'd1);
      check("run1_sig", 32'(r_sig), 32'(exp_full));
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
      check("run2_busy", 32'(r_busy), 32'd1);
      repeat (RP) tick();
      check("run2_done", 32'(r_done), 32'd1);
      check("run2_sig", 32'(r_sig), 32'(exp_full));

      // Random control traffic; the per-cycle model compare does the checking.
      for (int c = 0; c < 3000; c++) begin
         r_rst   = ($urandom_range(0, 99) == 0);
         r_abort = ($urandom_range(0, 39) == 0);
         r_start = ($urandom_range(0, 7) == 0);
         tick();
      end
      {r_rst, r_abort, r_start} = 3'b000;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
